// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem read, a 1-deep skid buffer for decode stalls, and flush/drain.
// Optional misaligned-fetch detection is enabled with `define FETCH_ALIGN_CHECK_EN.
module instr_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              pc_advance,
    output logic              fetch_fault
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

    state_t              state_q, state_d;
    logic                imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic                ir_valid_q, ir_valid_d;
    logic [DATA_W-1:0]   ir_data_q, ir_data_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
    logic                discard_q, discard_d;
    logic                pc_advance_q, pc_advance_d;
    logic                fetch_fault_q, fetch_fault_d;
    logic                slot_free;
    logic                misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign slot_free = !ir_valid_q || ir_ready;

    always_comb begin
        state_d       = state_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        ir_valid_d    = ir_valid_q;
        ir_data_d     = ir_data_q;
        ir_pc_d       = ir_pc_q;
        skid_data_d   = skid_data_q;
        skid_pc_d     = skid_pc_q;
        discard_d     = discard_q;
        pc_advance_d  = 1'b0;
        fetch_fault_d = fetch_fault_q;

        if (ir_valid_q && ir_ready) begin
            ir_valid_d    = 1'b0;
            fetch_fault_d = 1'b0;
        end

        if (flush) begin
            ir_valid_d    = 1'b0;
            fetch_fault_d = 1'b0;
            case (state_q)
                REQ: begin
                    discard_d = 1'b1;
                    if (imem_gnt) begin
                        imem_req_d = 1'b0;
                        state_d    = DRAIN;
                    end
                end
                WAIT:    state_d = imem_rvalid ? IDLE : DRAIN;
                DRAIN: begin
                    if (imem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    // pc only reflects the last advance one cycle after the pulse, so wait it out
                    if (!pc_advance_q) begin
                        if (misaligned) begin
                            if (slot_free) begin
                                ir_valid_d    = 1'b1;
                                ir_data_d     = '0;
                                ir_pc_d       = pc;
                                fetch_fault_d = 1'b1;
                                pc_advance_d  = 1'b1;
                            end
                        end else begin
                            imem_addr_d = pc;
                            imem_req_d  = 1'b1;
                            state_d     = REQ;
                        end
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        imem_req_d = 1'b0;
                        state_d    = discard_q ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        pc_advance_d = 1'b1;
                        if (slot_free) begin
                            ir_valid_d    = 1'b1;
                            ir_data_d     = imem_rdata;
                            ir_pc_d       = imem_addr_q;
                            fetch_fault_d = 1'b0;
                            state_d       = IDLE;
                        end else begin
                            skid_data_d = imem_rdata;
                            skid_pc_d   = imem_addr_q;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid_d = 1'b1;
                        ir_data_d  = skid_data_q;
                        ir_pc_d    = skid_pc_q;
                        state_d    = IDLE;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            ir_valid_q    <= 1'b0;
            ir_data_q     <= '0;
            ir_pc_q       <= '0;
            skid_data_q   <= '0;
            skid_pc_q     <= '0;
            discard_q     <= 1'b0;
            pc_advance_q  <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            ir_valid_q    <= ir_valid_d;
            ir_data_q     <= ir_data_d;
            ir_pc_q       <= ir_pc_d;
            skid_data_q   <= skid_data_d;
            skid_pc_q     <= skid_pc_d;
            discard_q     <= discard_d;
            pc_advance_q  <= pc_advance_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign ir_valid    = ir_valid_q;
    assign ir_data     = ir_data_q;
    assign ir_pc       = ir_pc_q;
    assign pc_advance  = pc_advance_q;
    assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle vector table, directed corner sequences,
// and a randomized run against a program-counter/memory/instruction-stream model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic        pc_advance;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
        .pc_advance(pc_advance), .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_data;
        logic [31:0] e_pc;
        logic        e_adv;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic f, input logic g, input logic r, input logic [31:0] d,
                                input logic rdy, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ed, input logic [31:0] ep,
                                input logic eadv);
        vec_t v;
        v.flush = f; v.gnt = g; v.rvalid = r; v.rdata = d; v.ready = rdy;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_data = ed; v.e_pc = ep; v.e_adv = eadv;
        return v;
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // program_counter stand-in: pc steps by 4 on every edge that sees pc_advance high
    task automatic tick();
        logic adv;
        adv = pc_advance;
        @(posedge clk);
        #1;
        if (adv) pc = pc + 32'd4;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; ir_ready = 1'b0; pc = start_pc;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!imem_req && n < 12) begin
            tick();
            n++;
        end
        check({tag, ".req_seen"}, 64'(imem_req), 64'd1);
    endtask

    task automatic grant_and_respond(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // flush gnt rvalid rdata ready | req addr valid data pc adv
        vecs[0]  = mk(0,0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0,0);
        vecs[1]  = mk(0,1,0,32'h0,0,        1,32'h0,0,32'h0,32'h0,0);
        vecs[2]  = mk(0,0,1,32'h20080005,0, 0,32'h0,0,32'h0,32'h0,0);
        vecs[3]  = mk(0,0,0,32'h0,0,        0,32'h0,1,32'h20080005,32'h0,1);
        vecs[4]  = mk(0,0,0,32'h0,0,        0,32'h0,1,32'h20080005,32'h0,0);
        vecs[5]  = mk(0,0,0,32'h0,1,        1,32'h4,1,32'h20080005,32'h0,0);
        vecs[6]  = mk(0,1,0,32'h0,0,        1,32'h4,0,32'h0,32'h0,0);
        vecs[7]  = mk(0,0,1,32'hAAAA0004,0, 0,32'h4,0,32'h0,32'h0,0);
        vecs[8]  = mk(0,0,0,32'h0,1,        0,32'h4,1,32'hAAAA0004,32'h4,1);
        vecs[9]  = mk(0,0,0,32'h0,0,        0,32'h4,0,32'h0,32'h0,0);
        vecs[10] = mk(0,0,0,32'h0,0,        1,32'h8,0,32'h0,32'h0,0);
        vecs[11] = mk(0,0,0,32'h0,0,        1,32'h8,0,32'h0,32'h0,0);
        vecs[12] = mk(0,0,0,32'h0,0,        1,32'h8,0,32'h0,32'h0,0);
        vecs[13] = mk(0,0,0,32'h0,0,        1,32'h8,0,32'h0,32'h0,0);
        vecs[14] = mk(0,1,0,32'h0,0,        1,32'h8,0,32'h0,32'h0,0);
        vecs[15] = mk(0,0,1,32'hBBBB0008,1, 0,32'h8,0,32'h0,32'h0,0);
        vecs[16] = mk(0,0,0,32'h0,1,        0,32'h8,1,32'hBBBB0008,32'h8,1);
        vecs[17] = mk(0,0,0,32'h0,0,        0,32'h8,0,32'h0,32'h0,0);
        vecs[18] = mk(0,0,0,32'h0,0,        1,32'hC,0,32'h0,32'h0,0);

        // ---- vector table: basic fetch, decode handshake, delayed grant ----
        do_reset(32'h0);
        for (int i = 0; i < 19; i++) begin
            check($sformatf("vec%0d.req", i),   64'(imem_req),   64'(vecs[i].e_req));
            check($sformatf("vec%0d.addr", i),  64'(imem_addr),  64'(vecs[i].e_addr));
            check($sformatf("vec%0d.valid", i), 64'(ir_valid),   64'(vecs[i].e_valid));
            check($sformatf("vec%0d.adv", i),   64'(pc_advance), 64'(vecs[i].e_adv));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d.data", i), 64'(ir_data), 64'(vecs[i].e_data));
                check($sformatf("vec%0d.irpc", i), 64'(ir_pc),   64'(vecs[i].e_pc));
            end
            $display("vec %0d: req=%0b addr=%h valid=%0b data=%h adv=%0b",
                     i, imem_req, imem_addr, ir_valid, ir_data, pc_advance);
            flush = vecs[i].flush; imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvalid;
            imem_rdata = vecs[i].rdata; ir_ready = vecs[i].ready;
            tick();
        end
        flush = 0; imem_gnt = 0; imem_rvalid = 0; ir_ready = 0;

        // ---- skid buffer under sustained stall ----
        do_reset(32'h0);
        wait_req("skid.a");
        grant_and_respond(32'h11111111);
        check("skid.first_valid", 64'(ir_valid), 64'd1);
        wait_req("skid.b");
        check("skid.second_addr", 64'(imem_addr), 64'h4);
        grant_and_respond(32'h22222222);
        check("skid.hold_data", 64'(ir_data), 64'h11111111);
        check("skid.hold_pc", 64'(ir_pc), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("skid.no_req%0d", i), 64'(imem_req), 64'd0);
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("skid.out_valid", 64'(ir_valid), 64'd1);
        check("skid.out_data", 64'(ir_data), 64'h22222222);
        check("skid.out_pc", 64'(ir_pc), 64'h4);
        $display("seq skid: data=%h pc=%h", ir_data, ir_pc);

        // ---- flush while waiting for data ----
        do_reset(32'h0);
        wait_req("fwait");
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0; pc = 32'h100;
        check("fwait.valid0", 64'(ir_valid), 64'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; tick(); imem_rvalid = 1'b0;
        check("fwait.no_adv", 64'(pc_advance), 64'd0);
        check("fwait.valid1", 64'(ir_valid), 64'd0);
        wait_req("fwait.next");
        check("fwait.addr", 64'(imem_addr), 64'h100);
        check("fwait.valid2", 64'(ir_valid), 64'd0);
        $display("seq flush-wait: next addr=%h", imem_addr);

        // ---- flush while request pending, then flush with a concurrent transfer ----
        flush = 1'b1; tick(); flush = 1'b0; pc = 32'h200;
        check("freq.req_kept", 64'(imem_req), 64'd1);
        check("freq.addr_kept", 64'(imem_addr), 64'h100);
        tick();
        check("freq.req_kept2", 64'(imem_req), 64'd1);
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h55555555; tick(); imem_rvalid = 1'b0;
        check("freq.valid", 64'(ir_valid), 64'd0);
        check("freq.no_adv", 64'(pc_advance), 64'd0);
        wait_req("freq.next");
        check("freq.addr", 64'(imem_addr), 64'h200);
        grant_and_respond(32'h77777777);
        check("freq.fill_data", 64'(ir_data), 64'h77777777);
        check("freq.fill_pc", 64'(ir_pc), 64'h200);
        flush = 1'b1; ir_ready = 1'b1; tick(); flush = 1'b0; ir_ready = 1'b0; pc = 32'h300;
        check("freq.flush_xfer_valid", 64'(ir_valid), 64'd0);
        $display("seq flush-req: valid=%0b", ir_valid);

        // ---- asynchronous reset in the middle of a read ----
        wait_req("rst");
        check("rst.addr", 64'(imem_addr), 64'h300);
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        check("rst.req", 64'(imem_req), 64'd0);
        check("rst.addr0", 64'(imem_addr), 64'd0);
        check("rst.valid", 64'(ir_valid), 64'd0);
        check("rst.data", 64'(ir_data), 64'd0);
        check("rst.irpc", 64'(ir_pc), 64'd0);
        check("rst.adv", 64'(pc_advance), 64'd0);
        check("rst.fault", 64'(fetch_fault), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        $display("seq reset-mid-read: outputs cleared");

        // ---- misaligned pc ----
        do_reset(32'h6);
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        check("align.fault", 64'(fetch_fault), 64'd1);
        check("align.valid", 64'(ir_valid), 64'd1);
        check("align.irpc", 64'(ir_pc), 64'h6);
        check("align.data", 64'(ir_data), 64'h0);
        check("align.req", 64'(imem_req), 64'd0);
        tick();
        check("align.req2", 64'(imem_req), 64'd0);
        flush = 1'b1; tick(); flush = 1'b0; pc = 32'h0;
        check("align.fault_clr", 64'(fetch_fault), 64'd0);
        check("align.valid_clr", 64'(ir_valid), 64'd0);
`else
        check("align.fault", 64'(fetch_fault), 64'd0);
        check("align.req", 64'(imem_req), 64'd1);
        check("align.addr", 64'(imem_addr), 64'h6);
`endif
        $display("seq misaligned: fault=%0b req=%0b", fetch_fault, imem_req);

        // ---- randomized run against instruction-stream model ----
        begin
            logic [31:0] exp_pc, mem_addr, prev_data, prev_pc, prev_addr, target;
            bit          mem_pending, hold_ir, hold_req;
            int          mem_cnt, transfers;
            do_reset(32'h0);
            exp_pc = 0; mem_addr = 0; prev_data = 0; prev_pc = 0; prev_addr = 0;
            mem_pending = 0; hold_ir = 0; hold_req = 0; mem_cnt = 0; transfers = 0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
                if (mem_pending) begin
                    if (mem_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = memf(mem_addr);
                    end
                end else if (imem_req && $urandom_range(0, 2) != 0) begin
                    imem_gnt = 1'b1;
                end
                ir_ready = ($urandom_range(0, 9) < 6);
                flush    = ($urandom_range(0, 29) == 0);
                target   = $urandom & 32'h0000FFFC;

                if (hold_ir) begin
                    check("rnd.ir_stable_valid", 64'(ir_valid), 64'd1);
                    check("rnd.ir_stable_data", 64'(ir_data), 64'(prev_data));
                    check("rnd.ir_stable_pc", 64'(ir_pc), 64'(prev_pc));
                end
                if (hold_req) begin
                    check("rnd.req_held", 64'(imem_req), 64'd1);
                    check("rnd.addr_held", 64'(imem_addr), 64'(prev_addr));
                end
                if (ir_valid && ir_ready && !flush) begin
                    check("rnd.xfer_pc", 64'(ir_pc), 64'(exp_pc));
                    check("rnd.xfer_data", 64'(ir_data), 64'(memf(exp_pc)));
                    check("rnd.xfer_fault", 64'(fetch_fault), 64'd0);
                    $display("rnd xfer %0d: pc=%h data=%h", transfers, ir_pc, ir_data);
                    exp_pc = exp_pc + 32'd4;
                    transfers++;
                end
                hold_ir   = ir_valid && !ir_ready && !flush;
                prev_data = ir_data;
                prev_pc   = ir_pc;
                hold_req  = imem_req && !imem_gnt;
                prev_addr = imem_addr;

                if (imem_gnt) begin
                    mem_pending = 1;
                    mem_addr    = imem_addr;
                    mem_cnt     = $urandom_range(0, 2);
                end else if (mem_pending) begin
                    if (mem_cnt == 0) mem_pending = 0;
                    else mem_cnt--;
                end

                tick();
                if (flush) begin
                    pc     = target;
                    exp_pc = target;
                end
            end
            flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; ir_ready = 1'b0;
            check("rnd.progress", 64'(transfers >= 50), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
